// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, widths and helpers for the keypad decoder
package keypad_pkg;
  localparam int KEY_W = 4;
  typedef enum logic [1:0] {IDLE, CANDIDATE, PRESSED, RELEASING} state_t;
  typedef enum logic [1:0] {NONE, KEY, MULTI} result_t;
  function automatic logic [1:0] enc2(input logic [KEY_W-1:0] v);
    return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: 2-flop synchronizer for the asynchronous keypad row lines
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] d,
  output logic [KEY_W-1:0] q
);
  logic [KEY_W-1:0] meta;
  // shift raw rows through two flops before anything looks at them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_decoder.sv
// keypad_decoder: debounced 4x4 keypad decoder; define KEYPAD_REPEAT_EN for held-key repeat strobes
module keypad_decoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_tick,
  input  logic [KEY_W-1:0] column,
  input  logic [KEY_W-1:0] row,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);
  localparam logic [4:0] DB = 5'(DEBOUNCE_SCANS);
  state_t state, state_n;
  result_t res;
  logic [KEY_W-1:0] row_s, count, count_n, cand, cand_n, code_n, s_code, t_code, acc_code;
  logic [1:0] s_hits, t_hits, acc_hits;
  logic [2:0] nrow, sum;
  logic [4:0] cnt_inc;
  logic onehot, frame_end, present, valid_n, held_n, rep_hit;

  keypad_row_sync u_sync (.clk(clk), .rst_n(rst_n), .d(row), .q(row_s));

  assign onehot    = column != '0 && (column & (column - 4'd1)) == '0;
  assign nrow      = 3'(row_s[0]) + 3'(row_s[1]) + 3'(row_s[2]) + 3'(row_s[3]);
  assign s_hits    = !onehot ? 2'd0 : nrow > 3'd1 ? 2'd2 : nrow[1:0];
  assign s_code    = {enc2(row_s), enc2(column)};
  assign sum       = 3'(acc_hits) + 3'(s_hits);
  assign t_hits    = sum > 3'd1 ? 2'd2 : sum[1:0];
  assign t_code    = acc_hits != 2'd0 ? acc_code : s_code;
  assign frame_end = scan_tick && column == 4'b1000;
  assign res       = t_hits == 2'd0 ? NONE : t_hits == 2'd1 ? KEY : MULTI;
  assign present   = res == MULTI || (res == KEY && t_code == key_code);
  assign cnt_inc   = 5'(count) + 5'd1;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep;
  assign rep_hit = frame_end && state == PRESSED && present && rep == RW'(REPEAT_SCANS - 1);
  // count frames spent holding an accepted key; wrap on each repeat strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rep <= '0;
    else if (frame_end) rep <= (state == PRESSED && present && !rep_hit) ? rep + 1'b1 : '0;
`else
  assign rep_hit = REPEAT_SCANS < 0;
`endif

  // next state: the debounce FSM only moves on a frame end
  always_comb begin
    state_n = state;
    count_n = count;
    cand_n  = cand;
    code_n  = key_code;
    held_n  = key_held;
    valid_n = 1'b0;
    if (frame_end)
      case (state)
        IDLE:
          if (res == KEY) begin
            cand_n = t_code;
            if (DB <= 5'd1) begin
              state_n = PRESSED;
              code_n  = t_code;
              valid_n = 1'b1;
              held_n  = 1'b1;
            end else begin
              state_n = CANDIDATE;
              count_n = 4'd1;
            end
          end
        CANDIDATE:
          if (res == KEY && t_code == cand) begin
            if (cnt_inc >= DB) begin
              state_n = PRESSED;
              count_n = '0;
              code_n  = cand;
              valid_n = 1'b1;
              held_n  = 1'b1;
            end else count_n = cnt_inc[3:0];
          end else if (res == KEY) begin
            cand_n  = t_code;
            count_n = 4'd1;
          end else begin
            state_n = IDLE;
            count_n = '0;
          end
        PRESSED:
          if (!present) begin
            state_n = DB <= 5'd1 ? IDLE : RELEASING;
            count_n = DB <= 5'd1 ? 4'd0 : 4'd1;
            held_n  = DB > 5'd1;
          end
        RELEASING:
          if (present) begin
            state_n = PRESSED;
            count_n = '0;
          end else if (cnt_inc >= DB) begin
            state_n = IDLE;
            count_n = '0;
            held_n  = 1'b0;
          end else count_n = cnt_inc[3:0];
        default: state_n = IDLE;
      endcase
  end

  // state, outputs and the per-frame hit accumulator
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      acc_hits  <= '0;
      acc_code  <= '0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      cand      <= cand_n;
      key_code  <= code_n;
      key_valid <= valid_n | rep_hit;
      key_held  <= held_n;
      acc_hits  <= scan_tick ? (frame_end ? 2'd0 : t_hits) : acc_hits;
      acc_code  <= scan_tick ? (frame_end ? 4'd0 : t_code) : acc_code;
    end
endmodule

// File: tb/tb_keypad_decoder.sv
// tb_keypad_decoder: table-driven, corner-case and randomized checks of keypad_decoder
module tb_keypad_decoder;
  localparam int DEB = 4;
  localparam int REP = 8;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP_EXP = 4;
`else
  localparam int REP_EXP = 1;
`endif
  logic clk = 0, rst_n = 1, scan_tick = 0;
  logic [3:0] column = 0, row = 0, key_code;
  logic key_valid, key_held;
  int errors = 0, checks = 0, nstrobe = 0, last_vcode = -1, gap_max = 0;
  int m_held, m_code, m_pend, m_run, m_rep, exp_s;

  typedef struct {
    logic [15:0] keys;
    int n;
    int strobes;
    int held;
    int code;
  } vec_t;
  vec_t tbl[14];

  always #5 clk = ~clk;

  keypad_decoder #(.DEBOUNCE_SCANS(DEB), .REPEAT_SCANS(REP)) dut (
    .clk(clk), .rst_n(rst_n), .scan_tick(scan_tick), .column(column), .row(row),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always @(negedge clk)
    if (key_valid) begin
      nstrobe++;
      last_vcode = int'(key_code);
    end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sample(input logic [3:0] col, input logic [3:0] r);
    column = col;
    row = r;
    repeat (3 + $urandom_range(0, gap_max)) @(negedge clk);
    scan_tick = 1;
    @(negedge clk);
    scan_tick = 0;
  endtask

  // one full scan of the 16-key mask; bit k = key k (row k/4, column k%4)
  task automatic frame(input logic [15:0] keys, input bit noise);
    for (int c = 0; c < 4; c++) begin
      if (noise && c == 2) sample(4'b0110, 4'b1111);
      sample(4'(1 << c), {keys[12+c], keys[8+c], keys[4+c], keys[c]});
    end
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_held = 0; m_code = 0; m_pend = -1; m_run = 0; m_rep = 0;
  endtask

  // frame-level reference: streak of identical single-key frames to accept, streak of absent frames to release
  task automatic model_frame(input logic [15:0] k, output int strobes);
    int n, c;
    n = $countones(k);
    c = -1;
    strobes = 0;
    if (n == 1) for (int i = 0; i < 16; i++) if (k[i]) c = i;
    if (!m_held) begin
      if (c >= 0) begin
        m_run = (c == m_pend) ? m_run + 1 : 1;
        m_pend = c;
        if (m_run >= DEB) begin
          m_held = 1; m_code = c; strobes = 1; m_pend = -1; m_run = 0; m_rep = 0;
        end
      end else begin
        m_pend = -1; m_run = 0;
      end
    end else if (n > 1 || c == m_code) begin
      if (m_run == 0) begin
        m_rep++;
`ifdef KEYPAD_REPEAT_EN
        if (m_rep == REP) begin strobes = 1; m_rep = 0; end
`endif
      end else begin
        m_run = 0; m_rep = 0;
      end
    end else begin
      m_run++;
      m_rep = 0;
      if (m_run >= DEB) begin m_held = 0; m_run = 0; m_pend = -1; end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] keys;
    int a, b, p, len;
    tbl[0]  = '{16'h0040, 3, 0, 0, 0};
    tbl[1]  = '{16'h0040, 1, 1, 1, 6};
    tbl[2]  = '{16'h0240, 3, 0, 1, 6};
    tbl[3]  = '{16'h0000, 3, 0, 1, 6};
    tbl[4]  = '{16'h0000, 1, 0, 0, 6};
    tbl[5]  = '{16'h0040, 2, 0, 0, 6};
    tbl[6]  = '{16'h0000, 1, 0, 0, 6};
    tbl[7]  = '{16'h0040, 3, 0, 0, 6};
    tbl[8]  = '{16'h0040, 1, 1, 1, 6};
    tbl[9]  = '{16'h0000, 4, 0, 0, 6};
    tbl[10] = '{16'h0200, 4, 1, 1, 9};
    tbl[11] = '{16'h8000, 1, 0, 1, 9};
    tbl[12] = '{16'h0200, 1, 0, 1, 9};
    tbl[13] = '{16'h0000, 4, 0, 0, 9};

    #3 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("reset_code", key_code, 0);
    chk("reset_valid", key_valid, 0);
    chk("reset_held", key_held, 0);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      nstrobe = 0;
      repeat (tbl[i].n) frame(tbl[i].keys, 0);
      chk($sformatf("tbl%0d_strobes", i), nstrobe, tbl[i].strobes);
      chk($sformatf("tbl%0d_held", i), key_held, tbl[i].held);
      chk($sformatf("tbl%0d_code", i), key_code, tbl[i].code);
      if (tbl[i].strobes > 0) chk($sformatf("tbl%0d_vcode", i), last_vcode, tbl[i].code);
    end

    nstrobe = 0;
    frame(16'h0040, 0);
    frame(16'h0040, 0);
    frame(16'h0040, 1);
    chk("noise_no_early", nstrobe, 0);
    frame(16'h0040, 0);
    chk("noise_strobe", nstrobe, 1);
    chk("noise_held", key_held, 1);
    repeat (4) frame(16'h0000, 0);

    repeat (4) frame(16'h0040, 0);
    chk("pre_reset_held", key_held, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_reset_held", key_held, 0);
    chk("mid_reset_code", key_code, 0);
    chk("mid_reset_valid", key_valid, 0);
    @(negedge clk);
    rst_n = 1;
    nstrobe = 0;
    repeat (3) frame(16'h0040, 0);
    chk("rearm_no_early", nstrobe, 0);
    chk("rearm_held_low", key_held, 0);
    frame(16'h0040, 0);
    chk("rearm_strobe", nstrobe, 1);
    chk("rearm_code", key_code, 6);
    repeat (4) frame(16'h0000, 0);

    nstrobe = 0;
    last_vcode = -1;
    repeat (28) frame(16'h0001, 0);
    chk("repeat_strobes", nstrobe, REP_EXP);
    chk("repeat_vcode", last_vcode, 0);
    chk("repeat_code", key_code, 0);
    repeat (4) frame(16'h0000, 0);

    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    gap_max = 2;
    a = 0;
    b = 1;
    for (int seg = 0; seg < 24; seg++) begin
      if (seg % 5 == 0) begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
      end
      p = $urandom_range(0, 5);
      len = $urandom_range(1, 6);
      keys = p == 0 ? 16'h0 : p == 3 ? 16'(1 << b) : p == 4 ? 16'((1 << a) | (1 << b)) : 16'(1 << a);
      for (int f = 0; f < len; f++) begin
        nstrobe = 0;
        frame(keys, $urandom_range(0, 3) == 0);
        model_frame(keys, exp_s);
        chk("rand_strobes", nstrobe, exp_s);
        chk("rand_held", key_held, m_held);
        chk("rand_code", key_code, m_code);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
